// File: rtl/inst_pc_control_if.sv
// rtl/inst_pc_control_if.sv - loop-control <-> PC sequencer bus
interface inst_pc_control_if #(
    parameter int InstMemAddrWidth = 32
);
    logic                        inst_jump;
    logic [InstMemAddrWidth-1:0] inst_jump_addr;
    logic                        inst_loop_done;
    logic [InstMemAddrWidth-1:0] inst_pc;

    modport master (
        output inst_jump,
        output inst_jump_addr,
        output inst_loop_done,
        input  inst_pc
    );

    modport slave (
        input  inst_jump,
        input  inst_jump_addr,
        input  inst_loop_done,
        output inst_pc
    );
endinterface

// File: rtl/inst_pc_control.sv
// rtl/inst_pc_control.sv - instruction PC sequencer: step, jump, halt, debug override
module inst_pc_control #(
    parameter int InstMemAddrWidth = 32,
    parameter int InstMemDepth     = 1024,
    parameter int ExecCountWidth   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic                        stall_i,
    input  logic                        dbg_en_i,
    input  logic                        dbg_pc_wr_i,
    input  logic [InstMemAddrWidth-1:0] dbg_pc_i,
    input  logic [1:0]                  inst_loop_mode_i,
    input  logic [InstMemAddrWidth-1:0] inst_prog_end_addr_i,
    inst_pc_control_if.slave            loop_if,
    output logic                        inst_valid_o,
    output logic                        inst_busy_o,
    output logic                        inst_done_o,
    output logic                        inst_err_o,
    output logic [ExecCountWidth-1:0]   inst_exec_count_o
);

    localparam logic [InstMemAddrWidth:0]   DepthExt = (InstMemAddrWidth+1)'(InstMemDepth);
    localparam logic [InstMemAddrWidth-1:0] LastPc   = InstMemAddrWidth'(InstMemDepth - 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    state_e                      state_q, state_d;
    logic [InstMemAddrWidth-1:0] pc_q, pc_d;
    logic                        err_q, err_d;
    logic                        done_q, done_d;
    logic [ExecCountWidth-1:0]   cnt_q, cnt_d;
    logic                        end_hit;
    logic                        jump_ok;
    logic                        dbg_ok;

    // Extra MSB keeps the range compare unsigned and safe when depth == 2^width.
    assign jump_ok = {1'b0, loop_if.inst_jump_addr} < DepthExt;
    assign dbg_ok  = {1'b0, dbg_pc_i} < DepthExt;
    assign end_hit = (inst_loop_mode_i != 2'd0) ? loop_if.inst_loop_done
                                                : (pc_q == inst_prog_end_addr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = IDLE;
            pc_d    = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pc_d = '0;
                    if (en_i) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        state_d = IDLE;
                        pc_d    = '0;
                    end else if (dbg_en_i) begin
                        if (dbg_pc_wr_i) begin
                            if (dbg_ok) pc_d  = dbg_pc_i;
                            else        err_d = 1'b1;
                        end
                    end else if (!stall_i) begin
                        cnt_d = cnt_q + ExecCountWidth'(1);
                        // Jumps only exist under loop control; mode 0 ignores them.
                        if (end_hit) begin
                            state_d = HALT;
                            done_d  = 1'b1;
                        end else if (inst_loop_mode_i != 2'd0 && loop_if.inst_jump) begin
                            if (jump_ok) begin
                                pc_d = loop_if.inst_jump_addr;
                            end else begin
                                err_d   = 1'b1;
                                state_d = HALT;
                            end
                        end else if (pc_q == LastPc) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d = pc_q + InstMemAddrWidth'(1);
                        end
                    end
                end
                HALT: begin
                    if (!en_i) begin
                        state_d = IDLE;
                        pc_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        inst_busy_o  = (state_q == RUN);
        inst_valid_o = (state_q == RUN) && !stall_i && !dbg_en_i;
    end

    assign loop_if.inst_pc   = pc_q;
    assign inst_done_o       = done_q;
    assign inst_err_o        = err_q;
    assign inst_exec_count_o = cnt_q;

endmodule
